wb_spi_arbiter: RTL

// Two-master Wishbone arbiter in front of the SPI flash controller (bus slot 2).

---
 rtl/wb_spi_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/wb_spi_arbiter.sv
// wb_spi_arbiter
// Two-master Wishbone arbiter in front of the SPI flash controller.
// Master 0 is the CPU bridge, master 1 the hardware flash-read engine.
// Ownership is round-robin. A master holding its lock keeps the grant between
// transactions, so a chip-select sequence is never interleaved with the other
// master. A watchdog frees a lock whose owner has stopped issuing cycles.
//
// Ports
//   clk_24m, rst            clock, asynchronous active-high reset
//   mX_addr/wdata/we/cyc    master X request (X = 0,1), cyc held until ack
//   mX_lock                 master X keep-grant request
//   mX_rdata, mX_ack        read data (shared s_rdata), one-cycle acknowledge
//   s_addr/wdata/we/cyc     muxed slave request, s_we gated by s_cyc
//   s_rdata, s_ack          slave response
//   grant                   one-hot owner (01 = m0, 10 = m1, 00 = none)
//   wdog_trip               one-cycle pulse when the watchdog frees a lock
module wb_spi_arbiter #(
  parameter int AW     = 4,
  parameter int DW     = 32,
  parameter int WDOG_W = 10
) (
  input  logic          clk_24m,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  input  logic          m0_cyc,
  input  logic          m0_lock,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  input  logic          m1_cyc,
  input  logic          m1_lock,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_we,
  output logic          s_cyc,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ack,
  output logic [1:0]    grant,
  output logic          wdog_trip
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  state_t            state, state_n;
  logic              last_owner;   // index of the master served most recently
  logic [1:0]        lock_blk;     // lock ignored after a trip until released
  logic [WDOG_W-1:0] wd_cnt;
  logic              trip;
  logic              own0, own1;
  logic              lock0_eff, lock1_eff;
  logic              locked_idle;
  logic              xact_done;
  state_t            arb_next;

  assign own0      = (state == OWN0);
  assign own1      = (state == OWN1);
  assign lock0_eff = m0_lock & ~lock_blk[0];
  assign lock1_eff = m1_lock & ~lock_blk[1];

  // Slave side: only the owner's request reaches the slave, GAP forces cyc low.
  assign s_cyc     = (own0 & m0_cyc) | (own1 & m1_cyc);
  assign s_addr    = own1 ? m1_addr  : m0_addr;
  assign s_wdata   = own1 ? m1_wdata : m0_wdata;
  assign s_we      = s_cyc & (own1 ? m1_we : m0_we);
  assign xact_done = s_cyc & s_ack;
  assign m0_ack    = own0 & xact_done;
  assign m1_ack    = own1 & xact_done;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

  assign locked_idle = (own0 & ~m0_cyc & lock0_eff) | (own1 & ~m1_cyc & lock1_eff);

  // Round-robin pick: on a tie the master that was not served last wins.
  always_comb begin
    arb_next = IDLE;
    if (m0_cyc && m1_cyc) arb_next = last_owner ? OWN0 : OWN1;
    else if (m0_cyc)      arb_next = OWN0;
    else if (m1_cyc)      arb_next = OWN1;
  end

  always_comb begin
    state_n = state;
    trip    = 1'b0;
    case (state)
      IDLE: state_n = arb_next;
      OWN0: begin
        if (xact_done) state_n = GAP;
        else if (!m0_cyc) begin
          if (!lock0_eff) state_n = IDLE;
          else if (&wd_cnt) begin
            state_n = IDLE;
            trip    = 1'b1;
          end
        end
      end
      OWN1: begin
        if (xact_done) state_n = GAP;
        else if (!m1_cyc) begin
          if (!lock1_eff) state_n = IDLE;
          else if (&wd_cnt) begin
            state_n = IDLE;
            trip    = 1'b1;
          end
        end
      end
      GAP: begin
        // last_owner was updated on the ack, so arb_next already favours the other master.
        if (last_owner == 1'b0 && lock0_eff)      state_n = OWN0;
        else if (last_owner == 1'b1 && lock1_eff) state_n = OWN1;
        else                                      state_n = arb_next;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_owner <= 1'b1;
      lock_blk   <= 2'b00;
      wd_cnt     <= '0;
      wdog_trip  <= 1'b0;
    end else begin
      state     <= state_n;
      wdog_trip <= trip;
      case (state_n)
        OWN0:    grant <= 2'b01;
        OWN1:    grant <= 2'b10;
        IDLE:    grant <= 2'b00;
        default: grant <= grant;  // GAP keeps the previous owner visible
      endcase
      if (m0_ack) last_owner <= 1'b0;
      if (m1_ack) last_owner <= 1'b1;
      if (state_n != state || s_ack) wd_cnt <= '0;
      else if (locked_idle && !(&wd_cnt)) wd_cnt <= wd_cnt + 1'b1;
      // Re-arm on release of the lock; a trip blocks the owner's lock.
      lock_blk[0] <= (lock_blk[0] | (trip & own0)) & m0_lock;
      lock_blk[1] <= (lock_blk[1] | (trip & own1)) & m1_lock;
    end
  end

endmodule
